aes_round_ctrl: RTL
===================

# aes_round_ctrl

Iterative AES encryption sequencer. Accepts one 128-bit plaintext block per handshake and runs the initial AddRoundKey followed by NR rounds, one round per clock, over the existing combinational SubBytes/ShiftRows/MixColumns/AddRoundKey datapath. MixColumns is bypassed on the final round. Round keys come from an external key schedule addressed by `rk_idx`, and the ciphertext is returned on a valid/ready output port.

## Interface
- `NR`, default 10: number of rounds. Legal values are 10, 12 and 14; any other value is illegal.
- `clk` input 1: clock. All state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: a plaintext block is offered.
- `in_ready` output 1: the block can accept a plaintext (high only in IDLE).
- `in_data` input 128: plaintext. Byte 0 is `[127:120]`; column-major state order as FIPS-197.
- `rk_idx` output 4: round-key index requested from the key schedule.
- `rk_in` input 128: round key for `rk_idx`, valid combinationally in the same cycle.
- `out_valid` output 1: ciphertext is valid.
- `out_ready` input 1: the consumer accepts the ciphertext.
- `out_data` output 128: ciphertext, same byte order as `in_data`.
- `busy` output 1: high in ROUND and DONE.
- `blk_cnt` output 16: completed-block count. Present only with `AES_ROUND_CTRL_BLKCNT_EN`.

## Operation
- **FSM states:** IDLE, ROUND, DONE. Implemented as a 2-bit state register with a 4-bit round counter `rnd`.
- **IDLE**
  - `in_ready`=1 and `rk_idx`=0.
  - On `in_valid & in_ready`: `st <= in_data ^ rk_in`, `rnd <= 1`, go to ROUND.
- **ROUND**
  - `rk_idx`=`rnd`.
  - `st <= AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), rk_in)`.
  - When `rnd==NR`, MixColumns is skipped, `st` receives the final ciphertext, and the FSM goes to DONE.
  - Otherwise `rnd <= rnd+1`.
  - `in_valid` is ignored while in ROUND.
- **DONE**
  - `out_valid`=1 and `out_data`=`st`, both held stable until `out_ready`=1.
  - On `out_valid & out_ready`: go to IDLE, `rnd <= 0`.
  - `st` keeps the last ciphertext; `out_data` is only meaningful while `out_valid`=1.
- **Arithmetic:** all operations are GF(2^8) and XOR, with no carries. `rnd` never exceeds NR and never wraps.
- **No bypass:** `in_ready` is not asserted in the same cycle as the `out_valid & out_ready` handshake.
- **rk_idx:** a pure function of state and `rnd`, with no glitch-dependent logic. It is 0 in DONE.

## Timing
- **Reset** (`rst_n`=0 at a rising edge), from any state including mid-ROUND and DONE:
  - state=IDLE, `rnd`=0, `st`=0;
  - `in_ready`=1 from the first cycle after reset is released;
  - `out_valid`=0, `out_data`=0, `busy`=0, `rk_idx`=0, `blk_cnt`=0.
- **Latency**, for an input accepted at edge T:
  - ROUND is active for cycles T+1 through T+NR;
  - `out_valid` rises after edge T+NR, so it is visible in cycle T+NR+1 (11 cycles for NR=10).
- **Throughput:**
  - with `out_ready` tied to 1, one block per NR+2 cycles (12 for NR=10);
  - `in_ready` reasserts the cycle after the output handshake.
- **Backpressure:** `out_ready`=0 holds DONE indefinitely with `out_data` stable. No input is accepted during this time.
- **Simultaneous events:** `in_valid` arriving in the same cycle as the output handshake is not accepted; it must be held until `in_ready`=1.

## Configuration
- **Macro:** `AES_ROUND_CTRL_BLKCNT_EN`.
- **Defined:**
  - adds the `blk_cnt` output port and a 16-bit register;
  - increments on every `out_valid & out_ready` handshake;
  - wraps from 0xFFFF to 0x0000;
  - cleared by reset.
- **Undefined:**
  - port and register are absent;
  - all other behaviour and timing are identical.

## Test plan
- **FIPS-197 C.1 vector:** key 000102030405060708090a0b0c0d0e0f (bench model supplies `rk_in` per `rk_idx`), plaintext 00112233445566778899aabbccddeeff.
  - `out_data`=69c4e0d86a7b0430d8cdb78070b4c55a.
  - `out_valid` appears 11 cycles after acceptance.
  - `rk_idx` sequence is 0,1,…,10.
- **FIPS-197 B vector:** key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734.
  - `out_data`=3925841d02dc09fbdc118597196a0b32.
- **Backpressure:** hold `out_ready`=0 for 20 cycles after `out_valid`.
  - `out_data` is stable throughout.
  - `in_ready`=0 throughout.
  - A single accept occurs on release.
- **Back-to-back blocks:** `in_valid` and `out_ready` held high with two blocks queued.
  - Second acceptance lands exactly 12 cycles after the first.
  - `in_valid` in the handshake cycle is not accepted.
- **Reset mid-operation:** pulse `rst_n`=0 at round 5.
  - Next cycle: `out_valid`=0, `rk_idx`=0, `in_ready`=1.
  - A following C.1 block still yields 69c4e0d86a7b0430d8cdb78070b4c55a.
- **With `AES_ROUND_CTRL_BLKCNT_EN`:**
  - three completed blocks give `blk_cnt`=3;
  - forcing 0xFFFF then completing one block gives 0x0000.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer: initial AddRoundKey then NR rounds, one per clock.
// Optional completed-block counter port blk_cnt is enabled by defining AES_ROUND_CTRL_BLKCNT_EN.
module aes_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
`ifdef AES_ROUND_CTRL_BLKCNT_EN
    ,
    output logic [15:0]  blk_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } stateT;

    localparam logic [3:0] LastRnd = 4'(NR);

    stateT        state, nextState;
    logic [3:0]   rnd, nextRnd;
    logic [127:0] st, nextSt, roundOut;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Multiplicative inverse as b^254 (zero maps to zero), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        inv = b;
        for (int unsigned i = 0; i < 6; i++) inv = gfMul(gfMul(inv, inv), b);
        inv = gfMul(inv, inv);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aesRound(input logic [127:0] s, input logic [127:0] key,
                                              input logic lastRound);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) b[i] = sbox(s[127 - 8*i -: 8]);
        // ShiftRows: row rw of column c takes the byte from column (c + rw) mod 4.
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned rw = 0; rw < 4; rw++)
                t[rw + 4*c] = b[rw + 4*((c + rw) % 4)];
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = t[4*c];
            a1 = t[4*c + 1];
            a2 = t[4*c + 2];
            a3 = t[4*c + 3];
            if (lastRound) begin
                r[127 - 32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                r[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                       a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                       a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                       xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return r ^ key;
    endfunction

    assign roundOut = aesRound(st, rk_in, rnd == LastRnd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rnd   <= '0;
            st    <= '0;
        end else begin
            state <= nextState;
            rnd   <= nextRnd;
            st    <= nextSt;
        end
    end

    always_comb begin
        nextState = state;
        nextRnd   = rnd;
        nextSt    = st;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    nextState = ROUND;
                    nextRnd   = 4'd1;
                    nextSt    = in_data ^ rk_in;
                end
            end
            ROUND: begin
                nextSt = roundOut;
                if (rnd == LastRnd) nextState = DONE;
                else                nextRnd   = rnd + 4'd1;
            end
            DONE: begin
                if (out_ready) begin
                    nextState = IDLE;
                    nextRnd   = '0;
                end
            end
            default: begin
                nextState = IDLE;
                nextRnd   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rk_idx    = '0;
        case (state)
            IDLE:  in_ready = 1'b1;
            ROUND: begin
                busy   = 1'b1;
                rk_idx = rnd;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign out_data = st;

`ifdef AES_ROUND_CTRL_BLKCNT_EN
    logic [15:0] blkCnt;

    always_ff @(posedge clk) begin
        if (!rst_n)                          blkCnt <= '0;
        else if (state == DONE && out_ready) blkCnt <= blkCnt + 16'd1;
    end

    assign blk_cnt = blkCnt;
`endif

endmodule
